// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared state encoding and AXI response codes for the data SRAM to AXI4-Lite bridge.
package data_sram_axi_bridge_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        WR_REQ  = ST_WR_REQ,
        WR_RESP = ST_WR_RESP,
        DONE    = ST_DONE
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Turns one single-cycle SRAM-style data request into one AXI4-Lite transaction,
// holding the pipeline with stall_req until the response is back.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    input  logic        flush,
    output logic [31:0] ram_read_data,
    output logic        stall_req,
    output logic        bus_error,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    bridge_state_e   state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            flushed_q, flushed_d;
    logic            err_q, err_d;

    logic [31:0] araddr_d, awaddr_d, wdata_d, rd_data_d;
    logic [3:0]  wstrb_d;
    logic        arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;

    logic busy;
    logic wd_expired;
    logic discard;
    logic aw_done_now, w_done_now;

    assign busy = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                  (state_q == WR_REQ)  || (state_q == WR_RESP);

    // The expiry compares against TIMEOUT_CYCLES-1 so the phase lasts exactly TIMEOUT_CYCLES cycles.
    assign wd_expired  = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);
    assign discard     = flushed_q || flush;
    assign aw_done_now = aw_done_q || (awvalid && awready);
    assign w_done_now  = w_done_q || (wvalid && wready);

    assign bus_error = (state_q == DONE) && err_q && !flushed_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        araddr_d  = araddr;
        awaddr_d  = awaddr;
        wdata_d   = wdata;
        wstrb_d   = wstrb;
        rd_data_d = ram_read_data;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        stall_req = 1'b0;

        case (state_q)
            IDLE: begin
                // rst gates acceptance so stall_req reads 0 while reset is held.
                if (ram_en && !flush && rst) begin
                    stall_req = 1'b1;
                    araddr_d  = ram_addr;
                    awaddr_d  = ram_addr;
                    wdata_d   = ram_write_data;
                    wstrb_d   = ram_write_en;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    flushed_d = 1'b0;
                    err_d     = 1'b0;
                    if (ram_write_en != 4'b0000) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            RD_ADDR: begin
                stall_req = 1'b1;
                flushed_d = discard;
                if (arvalid && arready) begin
                    state_d  = RD_DATA;
                    rready_d = 1'b1;
                end else if (wd_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!discard) rd_data_d = '0;
                end else begin
                    arvalid_d = 1'b1;
                end
            end

            RD_DATA: begin
                stall_req = 1'b1;
                flushed_d = discard;
                if (rready && rvalid) begin
                    state_d = DONE;
                    err_d   = resp_is_error(rresp);
                    if (!discard) rd_data_d = rdata;
                end else if (wd_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!discard) rd_data_d = '0;
                end else begin
                    rready_d = 1'b1;
                end
            end

            WR_REQ: begin
                stall_req = 1'b1;
                flushed_d = discard;
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                if (aw_done_now && w_done_now) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (wd_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    awvalid_d = !aw_done_now;
                    wvalid_d  = !w_done_now;
                end
            end

            WR_RESP: begin
                stall_req = 1'b1;
                flushed_d = discard;
                if (bready && bvalid) begin
                    state_d = DONE;
                    err_d   = resp_is_error(bresp);
                end else if (wd_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    bready_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if ((TIMEOUT_CYCLES == 0) || (state_d != state_q) || !busy) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wd_cnt_q      <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            flushed_q     <= 1'b0;
            err_q         <= 1'b0;
            araddr        <= '0;
            awaddr        <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            ram_read_data <= '0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_cnt_q      <= wd_cnt_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            flushed_q     <= flushed_d;
            err_q         <= err_d;
            araddr        <= araddr_d;
            awaddr        <= awaddr_d;
            wdata         <= wdata_d;
            wstrb         <= wstrb_d;
            ram_read_data <= rd_data_d;
            arvalid       <= arvalid_d;
            rready        <= rready_d;
            awvalid       <= awvalid_d;
            wvalid        <= wvalid_d;
            bready        <= bready_d;
        end
    end

endmodule
